// File: rtl/rv32i_control_pkg.sv
// Shared encodings for the multicycle RV32I control unit:
// opcodes, funct3 enums, mux selects, FSM states and the control word.
package rv32i_control_pkg;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  typedef enum logic [2:0] {
    alu_add = 3'b000,
    alu_sll = 3'b001,
    alu_sra = 3'b010,
    alu_sub = 3'b011,
    alu_xor = 3'b100,
    alu_srl = 3'b101,
    alu_or  = 3'b110,
    alu_and = 3'b111
  } alu_ops;

  typedef enum logic [2:0] {
    beq  = 3'b000,
    bne  = 3'b001,
    blt  = 3'b100,
    bge  = 3'b101,
    bltu = 3'b110,
    bgeu = 3'b111
  } branch_funct3_t;

  typedef enum logic [2:0] {
    lb  = 3'b000,
    lh  = 3'b001,
    lw  = 3'b010,
    lbu = 3'b100,
    lhu = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    sb = 3'b000,
    sh = 3'b001,
    sw = 3'b010
  } store_funct3_t;

  typedef enum logic [2:0] {
    f3_add  = 3'b000,
    f3_sll  = 3'b001,
    f3_slt  = 3'b010,
    f3_sltu = 3'b011,
    f3_xor  = 3'b100,
    f3_sr   = 3'b101,
    f3_or   = 3'b110,
    f3_and  = 3'b111
  } arith_funct3_t;

  typedef enum logic [1:0] {
    pcmux_pc_plus4 = 2'd0,
    pcmux_alu_out  = 2'd1,
    pcmux_alu_mod2 = 2'd2
  } pcmux_sel_t;

  typedef enum logic {
    marmux_pc_out  = 1'b0,
    marmux_alu_out = 1'b1
  } marmux_sel_t;

  typedef enum logic {
    cmpmux_rs2_out = 1'b0,
    cmpmux_i_imm   = 1'b1
  } cmpmux_sel_t;

  typedef enum logic {
    alumux1_rs1_out = 1'b0,
    alumux1_pc_out  = 1'b1
  } alumux1_sel_t;

  typedef enum logic [2:0] {
    alumux2_i_imm   = 3'd0,
    alumux2_u_imm   = 3'd1,
    alumux2_b_imm   = 3'd2,
    alumux2_s_imm   = 3'd3,
    alumux2_j_imm   = 3'd4,
    alumux2_rs2_out = 3'd5
  } alumux2_sel_t;

  typedef enum logic [3:0] {
    rfmux_alu_out  = 4'd0,
    rfmux_br_en    = 4'd1,
    rfmux_u_imm    = 4'd2,
    rfmux_lw       = 4'd3,
    rfmux_pc_plus4 = 4'd4,
    rfmux_lb       = 4'd5,
    rfmux_lbu      = 4'd6,
    rfmux_lh       = 4'd7,
    rfmux_lhu      = 4'd8
  } regfilemux_sel_t;

  typedef enum logic [4:0] {
    s_fetch1,
    s_fetch2,
    s_fetch3,
    s_decode,
    s_imm,
    s_reg,
    s_lui,
    s_auipc,
    s_br,
    s_jal,
    s_jalr,
    s_calc_ld,
    s_calc_st,
    s_ld1,
    s_ld2,
    s_st1,
    s_st2
  } ctrl_state_t;

  typedef struct packed {
    pcmux_sel_t      pcmux_sel;
    marmux_sel_t     marmux_sel;
    cmpmux_sel_t     cmpmux_sel;
    alumux1_sel_t    alumux1_sel;
    alumux2_sel_t    alumux2_sel;
    regfilemux_sel_t regfilemux_sel;
    alu_ops          aluop;
    branch_funct3_t  cmpop;
    logic            load_pc;
    logic            load_ir;
    logic            load_regfile;
    logic            load_mar;
    logic            load_mdr;
    logic            load_data_out;
    logic            mem_read;
    logic            mem_write;
    logic [3:0]      mem_byte_enable;
    logic            illegal_instr;
  } ctrl_word_t;

  localparam ctrl_word_t CW_DEFAULT = '{
    pcmux_sel:       pcmux_pc_plus4,
    marmux_sel:      marmux_pc_out,
    cmpmux_sel:      cmpmux_rs2_out,
    alumux1_sel:     alumux1_rs1_out,
    alumux2_sel:     alumux2_i_imm,
    regfilemux_sel:  rfmux_alu_out,
    aluop:           alu_add,
    cmpop:           beq,
    load_pc:         1'b0,
    load_ir:         1'b0,
    load_regfile:    1'b0,
    load_mar:        1'b0,
    load_mdr:        1'b0,
    load_data_out:   1'b0,
    mem_read:        1'b0,
    mem_write:       1'b0,
    mem_byte_enable: 4'b1111,
    illegal_instr:   1'b0
  };

  function automatic logic is_legal(logic [6:0] op);
    unique case (op)
      op_lui, op_auipc, op_jal, op_jalr, op_br,
      op_load, op_store, op_imm, op_reg: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Immediate forms never subtract: imm[10] only selects sra.
  function automatic alu_ops arith_aluop(
    logic [2:0] f3,
    logic       f7b5,
    logic       is_reg
  );
    if (f3 == f3_sr && f7b5)
      return alu_sra;
    if (f3 == f3_add && f7b5 && is_reg)
      return alu_sub;
    return alu_ops'(f3);
  endfunction

endpackage

// File: rtl/rv32i_control_if.sv
// Control-unit boundary: IR fields and status in,
// mux selects, load enables and memory strobes out.
interface rv32i_control_if;
  import rv32i_control_pkg::*;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rd;
  logic            br_en;
  logic [1:0]      mar_lsb;
  logic            mem_resp;

  pcmux_sel_t      pcmux_sel;
  marmux_sel_t     marmux_sel;
  cmpmux_sel_t     cmpmux_sel;
  alumux1_sel_t    alumux1_sel;
  alumux2_sel_t    alumux2_sel;
  regfilemux_sel_t regfilemux_sel;
  alu_ops          aluop;
  branch_funct3_t  cmpop;
  logic            load_pc;
  logic            load_ir;
  logic            load_regfile;
  logic            load_mar;
  logic            load_mdr;
  logic            load_data_out;
  logic            mem_read;
  logic            mem_write;
  logic [3:0]      mem_byte_enable;
  logic            illegal_instr;

  modport master (
    input  opcode, funct3, funct7, rd,
    input  br_en, mar_lsb, mem_resp,
    output pcmux_sel, marmux_sel, cmpmux_sel,
    output alumux1_sel, alumux2_sel,
    output regfilemux_sel, aluop, cmpop,
    output load_pc, load_ir, load_regfile,
    output load_mar, load_mdr, load_data_out,
    output mem_read, mem_write,
    output mem_byte_enable, illegal_instr
  );

  modport slave (
    output opcode, funct3, funct7, rd,
    output br_en, mar_lsb, mem_resp,
    input  pcmux_sel, marmux_sel, cmpmux_sel,
    input  alumux1_sel, alumux2_sel,
    input  regfilemux_sel, aluop, cmpop,
    input  load_pc, load_ir, load_regfile,
    input  load_mar, load_mdr, load_data_out,
    input  mem_read, mem_write,
    input  mem_byte_enable, illegal_instr
  );

endinterface

// File: rtl/rv32i_ctrl_signals.sv
// Combinational control word: current state + IR fields
// to every datapath select, load enable and memory strobe.
module rv32i_ctrl_signals
  import rv32i_control_pkg::*;
(
  input  ctrl_state_t state,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        funct7_b5,
  input  logic [4:0]  rd,
  input  logic        br_en,
  input  logic [1:0]  mar_lsb,
  output ctrl_word_t  cw
);

  always_comb begin
    cw = CW_DEFAULT;
    unique case (state)
      s_fetch1: cw.load_mar = 1'b1;
      s_fetch2: begin
        cw.mem_read = 1'b1;
        cw.load_mdr = 1'b1;
      end
      s_fetch3: cw.load_ir = 1'b1;
      s_decode: begin
        if (!is_legal(opcode)) begin
          cw.illegal_instr = 1'b1;
          cw.load_pc       = 1'b1;
        end
      end
      s_imm, s_reg: begin
        cw.aluop = arith_aluop(funct3, funct7_b5,
                               state == s_reg);
        if (state == s_reg) begin
          cw.alumux2_sel = alumux2_rs2_out;
          cw.cmpmux_sel  = cmpmux_rs2_out;
        end else begin
          cw.alumux2_sel = alumux2_i_imm;
          cw.cmpmux_sel  = cmpmux_i_imm;
        end
        if (funct3 == f3_slt || funct3 == f3_sltu) begin
          cw.cmpop = (funct3 == f3_slt) ? blt : bltu;
          cw.regfilemux_sel = rfmux_br_en;
        end
        cw.load_regfile = 1'b1;
        cw.load_pc      = 1'b1;
      end
      s_lui: begin
        cw.regfilemux_sel = rfmux_u_imm;
        cw.load_regfile   = 1'b1;
        cw.load_pc        = 1'b1;
      end
      s_auipc: begin
        cw.alumux1_sel  = alumux1_pc_out;
        cw.alumux2_sel  = alumux2_u_imm;
        cw.load_regfile = 1'b1;
        cw.load_pc      = 1'b1;
      end
      s_br: begin
        cw.cmpop       = branch_funct3_t'(funct3);
        cw.alumux1_sel = alumux1_pc_out;
        cw.alumux2_sel = alumux2_b_imm;
        cw.pcmux_sel   = br_en ? pcmux_alu_out
                               : pcmux_pc_plus4;
        cw.load_pc     = 1'b1;
      end
      s_jal: begin
        cw.regfilemux_sel = rfmux_pc_plus4;
        cw.alumux1_sel    = alumux1_pc_out;
        cw.alumux2_sel    = alumux2_j_imm;
        cw.pcmux_sel      = pcmux_alu_out;
        cw.load_regfile   = 1'b1;
        cw.load_pc        = 1'b1;
      end
      s_jalr: begin
        cw.regfilemux_sel = rfmux_pc_plus4;
        cw.alumux2_sel    = alumux2_i_imm;
        cw.pcmux_sel      = pcmux_alu_mod2;
        cw.load_regfile   = 1'b1;
        cw.load_pc        = 1'b1;
      end
      s_calc_ld, s_calc_st: begin
        cw.aluop      = alu_add;
        cw.marmux_sel = marmux_alu_out;
        cw.load_mar   = 1'b1;
        if (state == s_calc_st) begin
          cw.alumux2_sel   = alumux2_s_imm;
          cw.load_data_out = 1'b1;
        end
      end
      s_ld1: begin
        cw.mem_read = 1'b1;
        cw.load_mdr = 1'b1;
      end
      s_ld2: begin
        unique case (funct3)
          lb:      cw.regfilemux_sel = rfmux_lb;
          lh:      cw.regfilemux_sel = rfmux_lh;
          lbu:     cw.regfilemux_sel = rfmux_lbu;
          lhu:     cw.regfilemux_sel = rfmux_lhu;
          default: cw.regfilemux_sel = rfmux_lw;
        endcase
        cw.load_regfile = 1'b1;
        cw.load_pc      = 1'b1;
      end
      s_st1: begin
        cw.mem_write = 1'b1;
        unique case (funct3)
          sb:      cw.mem_byte_enable = 4'b0001 << mar_lsb;
          sh:      cw.mem_byte_enable = 4'b0011 << mar_lsb;
          default: cw.mem_byte_enable = 4'b1111;
        endcase
      end
      s_st2: cw.load_pc = 1'b1;
      default: cw = CW_DEFAULT;
    endcase
    // x0 is hardwired; never let a write reach it
    if (rd == 5'd0)
      cw.load_regfile = 1'b0;
  end

endmodule

// File: rtl/rv32i_control.sv
// Multicycle RV32I control FSM: state register and
// next-state sequencing; control word comes from rv32i_ctrl_signals.
module rv32i_control
  import rv32i_control_pkg::*;
(
  input logic           clk,
  input logic           rst_n,
  rv32i_control_if.master bus
);

  ctrl_state_t state;
  ctrl_word_t  cw_raw;
  ctrl_word_t  cw;
  logic        unused_funct7;

  assign unused_funct7 = ^{bus.funct7[6], bus.funct7[4:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= s_fetch1;
    end else begin
      unique case (state)
        s_fetch1: state <= s_fetch2;
        s_fetch2: if (bus.mem_resp) state <= s_fetch3;
        s_fetch3: state <= s_decode;
        s_decode: begin
          unique case (bus.opcode)
            op_imm:   state <= s_imm;
            op_reg:   state <= s_reg;
            op_lui:   state <= s_lui;
            op_auipc: state <= s_auipc;
            op_br:    state <= s_br;
            op_jal:   state <= s_jal;
            op_jalr:  state <= s_jalr;
            op_load:  state <= s_calc_ld;
            op_store: state <= s_calc_st;
            default:  state <= s_fetch1;
          endcase
        end
        s_calc_ld: state <= s_ld1;
        s_calc_st: state <= s_st1;
        s_ld1: if (bus.mem_resp) state <= s_ld2;
        s_st1: if (bus.mem_resp) state <= s_st2;
        default: state <= s_fetch1;
      endcase
    end
  end

  rv32i_ctrl_signals u_signals (
    .state     (state),
    .opcode    (bus.opcode),
    .funct3    (bus.funct3),
    .funct7_b5 (bus.funct7[5]),
    .rd        (bus.rd),
    .br_en     (bus.br_en),
    .mar_lsb   (bus.mar_lsb),
    .cw        (cw_raw)
  );

  // Strobes drop the instant reset asserts, not a clock later
  assign cw = rst_n ? cw_raw : CW_DEFAULT;

  assign bus.pcmux_sel       = cw.pcmux_sel;
  assign bus.marmux_sel      = cw.marmux_sel;
  assign bus.cmpmux_sel      = cw.cmpmux_sel;
  assign bus.alumux1_sel     = cw.alumux1_sel;
  assign bus.alumux2_sel     = cw.alumux2_sel;
  assign bus.regfilemux_sel  = cw.regfilemux_sel;
  assign bus.aluop           = cw.aluop;
  assign bus.cmpop           = cw.cmpop;
  assign bus.load_pc         = cw.load_pc;
  assign bus.load_ir         = cw.load_ir;
  assign bus.load_regfile    = cw.load_regfile;
  assign bus.load_mar        = cw.load_mar;
  assign bus.load_mdr        = cw.load_mdr;
  assign bus.load_data_out   = cw.load_data_out;
  assign bus.mem_read        = cw.mem_read;
  assign bus.mem_write       = cw.mem_write;
  assign bus.mem_byte_enable = cw.mem_byte_enable;
  assign bus.illegal_instr   = cw.illegal_instr;

endmodule
